// File: rtl/kalman_fpop_arbiter.sv
// Shares one fixed-latency FP operator among NREQ requesters and returns tagged results.
// Define KALMAN_ARB_ROUNDROBIN_EN for round-robin grants; otherwise the lowest index wins.
module kalman_fpop_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OPLAT = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       reqvalid,
   input  logic [NREQ*WIDTH-1:0] reqdataa,
   input  logic [NREQ*WIDTH-1:0] reqdatab,
   output logic [NREQ-1:0]       reqready,
   output logic [WIDTH-1:0]      opdataa,
   output logic [WIDTH-1:0]      opdatab,
   output logic                  opvalida,
   output logic                  opvalidb,
   input  logic [WIDTH-1:0]      opresult,
   output logic [NREQ-1:0]       respvalid,
   output logic [WIDTH-1:0]      respresult,
   output logic                  busy
);
   localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDXW-1:0]  grant_idx;
   logic             grant_any;
   logic             xfer;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   logic [OPLAT:0]   tag_valid_q;
   logic [IDXW-1:0]  tag_idx_q [OPLAT+1];
   logic [WIDTH-1:0] opdataa_q;
   logic [WIDTH-1:0] opdatab_q;
   logic [WIDTH-1:0] respresult_q;
   logic [NREQ-1:0]  respvalid_q;
   logic [NREQ-1:0]  resp_onehot;

`ifdef KALMAN_ARB_ROUNDROBIN_EN
   logic [IDXW-1:0] ptr_q;
   logic [IDXW-1:0] idx_hi;
   logic            found_hi;

   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      idx_hi    = '0;
      found_hi  = 1'b0;
      // Descending scan: the last write is the lowest qualifying index.
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (reqvalid[i]) begin
            grant_idx = IDXW'(i);
            grant_any = 1'b1;
            if (i > int'(ptr_q)) begin
               idx_hi   = IDXW'(i);
               found_hi = 1'b1;
            end
         end
      end
      if (found_hi) grant_idx = idx_hi;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_q <= IDXW'(NREQ - 1);
      end else if (xfer) begin
         ptr_q <= grant_idx;
      end
   end
`else
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (reqvalid[i]) begin
            grant_idx = IDXW'(i);
            grant_any = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      reqready = '0;
      if (reset && grant_any) reqready[grant_idx] = 1'b1;
   end

   assign xfer = |(reqvalid & reqready);

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_idx == IDXW'(i)) begin
            sel_a = reqdataa[i*WIDTH +: WIDTH];
            sel_b = reqdatab[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      resp_onehot = '0;
      if (tag_valid_q[OPLAT]) resp_onehot[tag_idx_q[OPLAT]] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tag_valid_q  <= '0;
         opdataa_q    <= '0;
         opdatab_q    <= '0;
         respvalid_q  <= '0;
         respresult_q <= '0;
         for (int i = 0; i <= int'(OPLAT); i++) tag_idx_q[i] <= '0;
      end else begin
         tag_valid_q  <= {tag_valid_q[OPLAT-1:0], xfer};
         tag_idx_q[0] <= grant_idx;
         for (int i = 1; i <= int'(OPLAT); i++) tag_idx_q[i] <= tag_idx_q[i-1];
         if (xfer) begin
            opdataa_q <= sel_a;
            opdatab_q <= sel_b;
         end
         respvalid_q <= resp_onehot;
         if (tag_valid_q[OPLAT]) respresult_q <= opresult;
      end
   end

   // Stage 0 of the tag pipeline is exactly the operator's input-valid cycle.
   assign opvalida   = tag_valid_q[0];
   assign opvalidb   = tag_valid_q[0];
   assign opdataa    = opdataa_q;
   assign opdatab    = opdatab_q;
   assign respvalid  = respvalid_q;
   assign respresult = respresult_q;
   assign busy       = |tag_valid_q;

endmodule

// File: tb/tb_kalman_fpop_arbiter.sv
// Scoreboard bench for kalman_fpop_arbiter with a latency-6 single-precision multiplier model.
module tb_kalman_fpop_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int OPLAT = 6;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic [NREQ-1:0]       reqvalid = '0;
   logic [NREQ*WIDTH-1:0] reqdataa = '0;
   logic [NREQ*WIDTH-1:0] reqdatab = '0;
   logic [NREQ-1:0]       reqready;
   logic [WIDTH-1:0]      opdataa;
   logic [WIDTH-1:0]      opdatab;
   logic                  opvalida;
   logic                  opvalidb;
   logic [WIDTH-1:0]      opresult;
   logic [NREQ-1:0]       respvalid;
   logic [WIDTH-1:0]      respresult;
   logic                  busy;

   kalman_fpop_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPLAT(OPLAT)) dut (
      .clock(clock), .reset(reset), .reqvalid(reqvalid), .reqdataa(reqdataa),
      .reqdatab(reqdatab), .reqready(reqready), .opdataa(opdataa), .opdatab(opdatab),
      .opvalida(opvalida), .opvalidb(opvalidb), .opresult(opresult), .respvalid(respvalid),
      .respresult(respresult), .busy(busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int xfer_count = 0;
   int opv_count = 0;
   logic [NREQ-1:0] gnt_seen = '0;

   typedef struct { int idx; logic [31:0] res; int acc; int due; } exp_t;
   typedef struct { logic [NREQ-1:0] rv; logic [31:0] res; int cyc; } obs_t;
   exp_t sbq[$];
   obs_t obs_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Round-to-nearest-even single-precision multiply for normal operands.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [23:0] m;
      logic        guard;
      logic        sticky;
      int          e;
      int          sh;
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      sh = p[47] ? 24 : 23;
      if (p[47]) e++;
      m = 24'(p >> sh);
      guard = p[sh-1];
      sticky = (p & ((48'd1 << (sh - 1)) - 48'd1)) != 48'd0;
      if (guard && (sticky || m[0])) begin
         if (m == 24'hffffff) begin
            m = 24'h800000;
            e++;
         end else begin
            m = m + 24'd1;
         end
      end
      return {a[31] ^ b[31], 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
   endfunction

   // Operator: result appears OPLAT edges after the cycle its operands were presented.
   logic [31:0] oppipe [OPLAT];
   always @(posedge clock) begin
      oppipe[0] <= fmul(opdataa, opdatab);
      for (int k = 1; k < OPLAT; k++) oppipe[k] <= oppipe[k-1];
   end
   assign opresult = oppipe[OPLAT-1];

   always @(posedge clock) begin
      cyc      <= cyc + 1;
      gnt_seen <= reqvalid & reqready;
      if (reset) xfer_count <= xfer_count + $countones(reqvalid & reqready);
   end

`ifdef KALMAN_ARB_ROUNDROBIN_EN
   int ptr_m = NREQ - 1;
   function automatic int pick(input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++) if (v[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
      return -1;
   endfunction
`else
   function automatic int pick(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) if (v[k]) return k;
      return -1;
   endfunction
`endif

   // Reference model: predicts grants, issue data, busy and pushes expected responses.
   logic        exp_opv = 1'b0;
   logic [31:0] exp_opa = '0;
   logic [31:0] exp_opb = '0;
   initial forever begin
      int g;
      logic bz;
      @(negedge clock);
      if (!reset) begin
         sbq.delete();
`ifdef KALMAN_ARB_ROUNDROBIN_EN
         ptr_m = NREQ - 1;
`endif
         exp_opv = 1'b0;
         exp_opa = '0;
         exp_opb = '0;
      end else begin
         check("opvalida", 32'(opvalida), 32'(exp_opv));
         check("opvalidb", 32'(opvalidb), 32'(exp_opv));
         check("opdataa", opdataa, exp_opa);
         check("opdatab", opdatab, exp_opb);
         bz = 1'b0;
         foreach (sbq[k]) if (sbq[k].acc <= cyc && cyc < sbq[k].due) bz = 1'b1;
         check("busy", 32'(busy), 32'(bz));
         g = pick(reqvalid);
         check("reqready", 32'(reqready), (g >= 0) ? (32'd1 << g) : 32'd0);
         exp_opv = (g >= 0);
         if (g >= 0) begin
            exp_opa = reqdataa[g*WIDTH +: WIDTH];
            exp_opb = reqdatab[g*WIDTH +: WIDTH];
            sbq.push_back('{idx: g, res: fmul(exp_opa, exp_opb), acc: cyc + 1,
                            due: cyc + OPLAT + 2});
`ifdef KALMAN_ARB_ROUNDROBIN_EN
            ptr_m = g;
`endif
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a response.
   initial forever begin
      exp_t e;
      @(negedge clock);
      if (!reset) begin
         check("rst_reqready", 32'(reqready), 32'd0);
         check("rst_opvalid", 32'({opvalida, opvalidb}), 32'd0);
         check("rst_opdataa", opdataa, 32'd0);
         check("rst_opdatab", opdatab, 32'd0);
         check("rst_respvalid", 32'(respvalid), 32'd0);
         check("rst_respresult", respresult, 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end else begin
         if (opvalida) opv_count++;
         if (respvalid != '0) begin
            obs_q.push_back('{rv: respvalid, res: respresult, cyc: cyc});
            if (sbq.size() == 0) begin
               check("unexpected_resp", 32'(respvalid), 32'd0);
            end else begin
               e = sbq.pop_front();
               check("resp_idx", 32'(respvalid), 32'd1 << e.idx);
               check("resp_data", respresult, e.res);
               check("resp_cycle", 32'(cyc), 32'(e.due));
            end
         end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check("resp_missing", 32'(respvalid), 32'd1 << e.idx);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
      reqdataa[i*WIDTH +: WIDTH] = a;
      reqdatab[i*WIDTH +: WIDTH] = b;
      reqvalid[i] = 1'b1;
   endtask

   task automatic wait_grant(input int i);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!gnt_seen[i] && n < 20);
      check("grant_timeout", 32'(gnt_seen[i]), 32'd1);
   endtask

   task automatic drain();
      repeat (OPLAT + 4) tick();
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int gaps;
      int bad;
      repeat (3) tick();
      reset = 1'b1;

      // Single request: 2.1 * 3.4
      obs_q.delete();
      set_req(0, 32'h40066666, 32'h4059999a);
      wait_grant(0);
      reqvalid[0] = 1'b0;
      drain();
      check("t1_count", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() > 0) begin
         check("t1_idx", 32'(obs_q[0].rv), 32'd1);
         check("t1_result", obs_q[0].res, 32'h40e47ae1);
      end

      // Back-to-back from req2: 0.2*0.3 then 0.5*0.54.
      // The exact single product 0.2f*0.3f rounds one ulp above the float nearest 0.06.
      obs_q.delete();
      set_req(2, 32'h3e4ccccd, 32'h3e99999a);
      wait_grant(2);
      set_req(2, 32'h3f000000, 32'h3f0a3d71);
      wait_grant(2);
      reqvalid[2] = 1'b0;
      drain();
      check("t3_count", 32'(obs_q.size()), 32'd2);
      if (obs_q.size() == 2) begin
         check("t3_idx0", 32'(obs_q[0].rv), 32'd4);
         check("t3_res0", obs_q[0].res, 32'h3d75c290);
         check("t3_res1", obs_q[1].res, 32'h3e8a3d71);
         check("t3_back2back", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'd1);
      end

      // req3 pulses for one cycle while req1 holds the grant
      set_req(0, rand_fp(), rand_fp());
      wait_grant(0);
      reqvalid[0] = 1'b0;
      set_req(1, rand_fp(), rand_fp());
      set_req(3, rand_fp(), rand_fp());
      tick();
      check("t5_grant", 32'(gnt_seen), 32'd2);
      reqvalid = '0;
      drain();

      // Reset while req1 is in flight
      set_req(1, rand_fp(), rand_fp());
      wait_grant(1);
      reqvalid[1] = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      obs_q.delete();
      repeat (2) tick();
      reset = 1'b1;
      drain();
      check("t4_no_resp", 32'(obs_q.size()), 32'd0);

      // All four requesters continuously valid
      for (int i = 0; i < NREQ; i++) set_req(i, rand_fp(), rand_fp());
      repeat (16) begin
         tick();
         for (int i = 0; i < NREQ; i++)
            if (gnt_seen[i]) set_req(i, rand_fp(), rand_fp());
      end
      reqvalid = '0;
      drain();
      check("t2_count", 32'(obs_q.size()), 32'd16);
      gaps = 0;
      bad = 0;
      for (int k = 0; k < obs_q.size(); k++) begin
         if (k > 0 && obs_q[k].cyc != obs_q[k-1].cyc + 1) gaps++;
`ifdef KALMAN_ARB_ROUNDROBIN_EN
         if (obs_q[k].rv != NREQ'(1 << (k % NREQ))) bad++;
`else
         if (obs_q[k].rv != NREQ'(1)) bad++;
`endif
      end
      check("t2_gaps", 32'(gaps), 32'd0);
      check("t2_order", 32'(bad), 32'd0);

      // Randomized traffic, including legal withdrawals before grant
      repeat (400) begin
         tick();
         for (int i = 0; i < NREQ; i++) begin
            if (gnt_seen[i]) reqvalid[i] = 1'b0;
            if (!reqvalid[i] && $urandom_range(0, 2) == 0) set_req(i, rand_fp(), rand_fp());
            else if (reqvalid[i] && $urandom_range(0, 15) == 0) reqvalid[i] = 1'b0;
         end
      end
      reqvalid = '0;
      drain();

      check("scoreboard_empty", 32'(sbq.size()), 32'd0);
      check("opvalid_count", 32'(opv_count), 32'(xfer_count));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
